// File: rtl/sync_cdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_cdc_pkg
// Description : Shared constants, types and helpers for the CDC read-side
//               receive buffer. The valid flag sits at the MSB of the
//               synchroniser word, and the payload fills the bits below it.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_cdc_pkg;

   localparam int DEFAULT_WIDTH = 193;
   localparam int VALID_BIT     = DEFAULT_WIDTH - 1;
   localparam int PAYLOAD_W     = DEFAULT_WIDTH - 1;
   localparam int DEFAULT_DEPTH = 4;
   localparam int DEFAULT_CNT_W = 16;

   // Outcome of the stage-2 push decision for the word held in the input register
   typedef enum logic [1:0] {
      PUSH_NONE   = 2'd0,
      PUSH_ACCEPT = 2'd1,
      PUSH_DROP   = 2'd2
   } push_res_e;

   // Pointer width: one extra bit distinguishes full from empty
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage : sync_cdc_pkg
`default_nettype wire

// File: rtl/sync_cdc_rx_ring.sv
`default_nettype none
// ============================================================================
// Module      : sync_cdc_rx_ring
// Description : DEPTH x DATA_W circular buffer with first-word-fall-through
//               read. Pointers carry one extra wrap bit; the buffer is empty
//               when the pointers match and full when only the wrap bit
//               differs. Memory is not reset; rd_data is forced to zero
//               while the buffer is empty.
// Ports       : clk, rst_n    - clock, asynchronous active-low reset
//               push, wr_data - write request (already qualified by the
//                               caller) and the word to store
//               pop           - read request; ignored while empty
//               rd_data       - head word (zero when empty)
//               rd_valid      - buffer not empty
//               full          - all DEPTH entries occupied
// Revision    : 1.0 - initial release
// ============================================================================
module sync_cdc_rx_ring
   import sync_cdc_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,   // power of two, minimum 2
   parameter int DATA_W = PAYLOAD_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_width(DEPTH);

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              empty;
   logic              pop_ok;

   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign pop_ok = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array: deliberately without reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

   // Masking with empty keeps the output at zero after reset even though
   // the array itself holds stale data
   assign rd_valid = !empty;
   assign rd_data  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

endmodule : sync_cdc_rx_ring
`default_nettype wire

// File: rtl/sync_cdc_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sync_cdc_rx_buffer
// Description : Read-domain consumer of the CDC synchroniser output. Each
//               valid word is registered, then pushed into a small ring
//               buffer. The buffer is presented downstream on a
//               valid/ready handshake. The upstream side cannot be
//               stalled, so a word that finds the buffer full is dropped.
//               Optional statistics count accepted and dropped words and
//               flag the first drop.
// Build macro : SYNC_CDC_RX_STATS_EN - enables word_cnt, drop_cnt and
//               overflow. When undefined, those outputs are tied to zero
//               and clr_cnt is ignored.
// Ports       : clk, rst_n - clock, asynchronous active-low reset
//               data_in    - [WIDTH-1] valid flag, [WIDTH-2:0] payload
//               out_data   - payload at the buffer head (zero when empty)
//               out_valid  - buffer not empty
//               out_ready  - downstream accepts the head word
//               clr_cnt    - synchronous clear of counters and overflow
//               word_cnt   - accepted words, saturating
//               drop_cnt   - dropped words, saturating
//               overflow   - sticky, set on the first drop
// Revision    : 1.0 - initial release
// ============================================================================
module sync_cdc_rx_buffer
   import sync_cdc_pkg::*;
#(
   parameter int WIDTH = VALID_BIT + 1,    // the valid flag is the word MSB
   parameter int DEPTH = DEFAULT_DEPTH,    // power of two, minimum 2
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-2:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] word_cnt,
   output logic [CNT_W-1:0] drop_cnt,
   output logic             overflow
);

   localparam int IN_VALID_BIT = WIDTH - 1;
   localparam int IN_PAYLOAD_W = WIDTH - 1;

   // ------------------------------------------------------------------
   // Stage 1: input register, loaded on every edge
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] in_q, in_d;
   logic             in_valid;

   always_comb begin
      in_d = data_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q <= '0;
      end else begin
         in_q <= in_d;
      end
   end

   assign in_valid = in_q[IN_VALID_BIT];

   // ------------------------------------------------------------------
   // Stage 2: push/drop decision
   // A full buffer still accepts a word when the head is popped in the
   // same cycle, so sustained one-in/one-out traffic never drops.
   // ------------------------------------------------------------------
   logic      ring_full;
   logic      ring_pop;
   push_res_e push_res;

   assign ring_pop = out_valid && out_ready;

   always_comb begin
      push_res = PUSH_NONE;
      if (in_valid) begin
         push_res = (!ring_full || ring_pop) ? PUSH_ACCEPT : PUSH_DROP;
      end
   end

   sync_cdc_rx_ring #(
      .DEPTH  (DEPTH),
      .DATA_W (IN_PAYLOAD_W)
   ) u_ring (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push_res == PUSH_ACCEPT),
      .wr_data  (in_q[IN_PAYLOAD_W-1:0]),
      .pop      (ring_pop),
      .rd_data  (out_data),
      .rd_valid (out_valid),
      .full     (ring_full)
   );

   // ------------------------------------------------------------------
   // Statistics
   // ------------------------------------------------------------------
`ifdef SYNC_CDC_RX_STATS_EN
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic             overflow_q, overflow_d;

   // A clear wins over an increment in the same cycle; that event is lost
   always_comb begin
      word_cnt_d = word_cnt_q;
      drop_cnt_d = drop_cnt_q;
      overflow_d = overflow_q;
      if (clr_cnt) begin
         word_cnt_d = '0;
         drop_cnt_d = '0;
         overflow_d = 1'b0;
      end else begin
         if ((push_res == PUSH_ACCEPT) && (word_cnt_q != '1)) begin
            word_cnt_d = word_cnt_q + 1'b1;
         end
         if (push_res == PUSH_DROP) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
               drop_cnt_d = drop_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt_q <= '0;
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         word_cnt_q <= word_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   assign word_cnt = word_cnt_q;
   assign drop_cnt = drop_cnt_q;
   assign overflow = overflow_q;
`else
   logic unused_clr_cnt;

   assign unused_clr_cnt = clr_cnt;
   assign word_cnt       = '0;
   assign drop_cnt       = '0;
   assign overflow       = 1'b0;
`endif

endmodule : sync_cdc_rx_buffer
`default_nettype wire

// File: tb/tb_sync_cdc_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_cdc_rx_buffer
// Description : Directed self-checking bench for sync_cdc_rx_buffer
//               (WIDTH 193, DEPTH 4, CNT_W 16). Expected statistics follow
//               the SYNC_CDC_RX_STATS_EN build macro; data ordering is the
//               same in both builds. Inputs change 1 ns after the rising
//               edge, and outputs are checked at that point.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sync_cdc_rx_buffer;

   localparam int WIDTH = 193;
   localparam int DEPTH = 4;
   localparam int CNT_W = 16;
   localparam int PW    = WIDTH - 1;
`ifdef SYNC_CDC_RX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] data_in;
   logic [PW-1:0]    out_data;
   logic             out_valid;
   logic             out_ready;
   logic             clr_cnt;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] drop_cnt;
   logic             overflow;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sync_cdc_rx_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .clr_cnt   (clr_cnt),
      .word_cnt  (word_cnt),
      .drop_cnt  (drop_cnt),
      .overflow  (overflow)
   );

   task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [PW-1:0] payload);
      data_in = {1'b1, payload};
   endtask

   task automatic idle();
      data_in = '0;
   endtask

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected end of sequence");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_word;
      int exp_drop;

      rst_n     = 1'b0;
      data_in   = '0;
      out_ready = 1'b0;
      clr_cnt   = 1'b0;
      exp_word  = 0;
      exp_drop  = 0;
      tick();
      tick();

      // ---------------- reset state ----------------
      check("rst_out_valid", PW'(out_valid), '0);
      check("rst_out_data",  out_data,       '0);
      check("rst_word_cnt",  PW'(word_cnt),  '0);
      check("rst_drop_cnt",  PW'(drop_cnt),  '0);
      check("rst_overflow",  PW'(overflow),  '0);
      rst_n = 1'b1;
      tick();

      // ---------------- 1: single word, two-edge latency ----------------
      send(PW'(1));
      out_ready = 1'b1;
      tick();                                   // word lands in the input register
      idle();
      check("t1_valid_edge1", PW'(out_valid), '0);
      tick();                                   // word written into the ring
      check("t1_valid_edge2", PW'(out_valid), PW'(1));
      check("t1_data",        out_data,       PW'(1));
      exp_word = STATS ? 1 : 0;
      check("t1_word_cnt",    PW'(word_cnt),  PW'(exp_word));
      tick();                                   // popped
      check("t1_popped",      PW'(out_valid), '0);

      // ---------------- 2: overflow with out_ready low ----------------
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         send(PW'(32'h10 + i));
         tick();
      end
      idle();
      tick();                                   // last word (0x15) dropped here
      exp_word = STATS ? 5 : 0;
      exp_drop = STATS ? 2 : 0;
      check("t2_word_cnt", PW'(word_cnt),  PW'(exp_word));
      check("t2_drop_cnt", PW'(drop_cnt),  PW'(exp_drop));
      check("t2_overflow", PW'(overflow),  PW'(STATS ? 1 : 0));
      check("t2_valid",    PW'(out_valid), PW'(1));
      check("t2_head",     out_data,       PW'(32'h10));
      tick();
      check("t2_hold_data",  out_data,       PW'(32'h10));
      check("t2_hold_valid", PW'(out_valid), PW'(1));
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t2_drain_%0d", k), out_data, PW'(32'h10 + k));
         tick();
      end
      check("t2_empty", PW'(out_valid), '0);

      // ---------------- 3: full buffer, one in / one out per cycle ----------------
      out_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin         // fill four entries, fifth word pending
         send(PW'(32'h100 + j));
         tick();
      end
      out_ready = 1'b1;
      for (int j = 5; j < 24; j++) begin
         send(PW'(32'h100 + j));
         check($sformatf("t3_stream_valid_%0d", j), PW'(out_valid), PW'(1));
         check($sformatf("t3_stream_data_%0d", j),  out_data,       PW'(32'h100 + j - 5));
         tick();
      end
      idle();
      for (int k = 19; k < 24; k++) begin
         check($sformatf("t3_tail_%0d", k), out_data, PW'(32'h100 + k));
         tick();
      end
      check("t3_empty", PW'(out_valid), '0);
      exp_word = STATS ? 29 : 0;
      check("t3_word_cnt", PW'(word_cnt), PW'(exp_word));
      check("t3_drop_cnt", PW'(drop_cnt), PW'(exp_drop));

      // ---------------- 4: invalid word is never stored ----------------
      data_in = {1'b0, PW'(32'hDEAD)};
      tick();
      tick();
      tick();
      idle();
      check("t4_valid",    PW'(out_valid), '0);
      check("t4_data",     out_data,       '0);
      check("t4_word_cnt", PW'(word_cnt),  PW'(exp_word));

      // ---------------- 5: clear coinciding with a drop ----------------
      out_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin         // 0x200..0x203 stored, 0x204 pending
         send(PW'(32'h200 + j));
         tick();
      end
      clr_cnt = 1'b1;
      send(PW'(32'h205));
      tick();                                   // 0x204 dropped while clearing
      clr_cnt = 1'b0;
      idle();
      check("t5_clr_drop",  PW'(drop_cnt), '0);
      check("t5_clr_ovf",   PW'(overflow), '0);
      check("t5_clr_word",  PW'(word_cnt), '0);
      tick();                                   // 0x205 dropped, counted
      check("t5_drop_cnt",  PW'(drop_cnt), PW'(STATS ? 1 : 0));
      check("t5_overflow",  PW'(overflow), PW'(STATS ? 1 : 0));
      check("t5_head_kept", out_data,      PW'(32'h200));

      // ---------------- 6: asynchronous reset with data buffered ----------------
      out_ready = 1'b1;
      tick();                                   // pop 0x200, three words remain
      out_ready = 1'b0;
      check("t6_head_before", out_data, PW'(32'h201));
      rst_n = 1'b0;
      #1;
      check("t6_async_valid", PW'(out_valid), '0);
      check("t6_async_data",  out_data,       '0);
      check("t6_async_word",  PW'(word_cnt),  '0);
      check("t6_async_drop",  PW'(drop_cnt),  '0);
      check("t6_async_ovf",   PW'(overflow),  '0);
      tick();
      rst_n = 1'b1;
      tick();
      send(PW'(7));
      tick();
      idle();
      check("t6_lat_edge1", PW'(out_valid), '0);
      tick();
      check("t6_lat_edge2", PW'(out_valid), PW'(1));
      check("t6_new_word",  out_data,       PW'(7));
      check("t6_word_cnt",  PW'(word_cnt),  PW'(STATS ? 1 : 0));
      out_ready = 1'b1;
      tick();
      check("t6_alone", PW'(out_valid), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_sync_cdc_rx_buffer
`default_nettype wire
